cascade_counter: RTL and testbench
==================================

CASCADE_COUNTER -- requirements
Module: cascade_counter

Interface
REQ-001 SHALL have parameter PRESCALE, default 100: clock cycles per count step; legal range 1 or more.
REQ-002 SHALL have parameter DIGITS, default 2: number of cascaded digit stages; legal range 1 or more.
REQ-003 SHALL have parameter MODULUS, default 5: states per digit, 0..MODULUS-1; legal range 2 or more.
REQ-004 SHALL derive local DW = max(1, clog2(MODULUS)) as the bits per digit.
REQ-005 SHALL have port clk  in  1  clock, rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port en  in  1  count enable; prescaler and digits hold when low.
REQ-008 SHALL have port up  in  1  direction: 1 counts up, 0 counts down.
REQ-009 SHALL have port load  in  1  synchronous load strobe.
REQ-010 SHALL have port load_val  in  DIGITS*DW  load value; digit 0 in the LSBs.
REQ-011 SHALL have port count  out  DIGITS*DW  registered digit values; digit 0 in the LSBs.
REQ-012 SHALL have port tick  out  1  one-cycle pulse, high in the cycle count shows a stepped value.
REQ-013 SHALL have port carry  out  1  one-cycle pulse, high in the cycle all digits have wrapped.

Function
REQ-014 SHALL run a prescaler 0..PRESCALE-1 that advances only when en=1; a tick event occurs when the prescaler is at PRESCALE-1 and en=1, after which the prescaler returns to 0.
REQ-015 With PRESCALE=1, a tick event SHALL occur on every cycle with en=1.
REQ-016 On a tick event, digit 0 SHALL step by one in the direction given by up.
REQ-017 On a tick event, digit i>0 SHALL step only if every lower digit is at terminal: MODULUS-1 when up=1, 0 when up=0.
REQ-018 A digit SHALL wrap MODULUS-1->0 when counting up and 0->MODULUS-1 when counting down.
REQ-019 carry SHALL pulse with tick when every digit was terminal before the step.
REQ-020 The value of up SHALL be sampled at the tick event; a direction change SHALL NOT affect the prescaler.
REQ-021 load=1 SHALL update count from load_val on the next cycle, clear the prescaler, and produce no tick or carry that cycle.
REQ-022 load SHALL take priority over en and tick events.
REQ-023 Any load_val digit of MODULUS or more SHALL be clamped to MODULUS-1.
REQ-024 Output latency SHALL be exactly one clock from the event to count, tick and carry.

Reset
REQ-025 rst=1 SHALL set count, the prescaler, tick and carry to 0 on the next edge.
REQ-026 rst SHALL take priority over load and en, including when asserted mid-prescale period.

Configuration
REQ-027 With macro CASCADE_COUNTER_SEG7_EN defined, the block SHALL add output seg[6:0]: a registered, active-high seven-segment decode of digit 0 (bit 0=a .. bit 6=g, hex glyphs 0-F), reset value 7'b0111111.
REQ-028 Without CASCADE_COUNTER_SEG7_EN, port seg and its decoder SHALL be absent and all other behaviour SHALL be unchanged.
REQ-029 When CASCADE_COUNTER_SEG7_EN is defined, seg SHALL update in the same cycle as count.

Structure
REQ-030 The shared package cascade_counter_pkg SHALL hold the default parameter constants and the 16-entry seven-segment glyph table.
REQ-031 Each digit SHALL be an instance of sub-module cascade_digit, with inputs step, up, load and value, and outputs digit and terminal; the top level SHALL chain the terminal flags.

Verification (PRESCALE=4, DIGITS=2, MODULUS=5; count shown as {d1,d0})
REQ-032 Hold rst=1 for 2 cycles -> count={0,0}, tick=0, carry=0 (seg=7'b0111111 if enabled).
REQ-033 en=1, up=1 from reset -> tick every 4th cycle; after 24 ticks count={4,4}; 25th tick gives {0,0} with carry=1 for one cycle.
REQ-034 en=1, up=0 from reset -> first tick (cycle 4) gives {4,4} with carry=1.
REQ-035 Pulse load with load_val={2,3} two cycles into a period -> next cycle count={2,3} with no tick; the next tick 4 cycles later gives {2,4}.
REQ-036 Drop en for 10 cycles mid-period -> count and prescaler frozen, no tick; the period resumes where it left off once en returns.
REQ-037 Load load_val={7,7} -> count={4,4}; with the macro enabled, load d0=3 -> seg=7'b1001111.

Source files
------------

// File: rtl/cascade_counter_pkg.sv
// Shared constants for the cascaded counter: default parameters, seven-segment glyphs, digit step rule.
// Latency: n/a (package only).
// Backpressure: n/a. Optional seven-segment output is enabled by CASCADE_COUNTER_SEG7_EN.
package cascade_counter_pkg;

   localparam int DEF_PRESCALE = 100;
   localparam int DEF_DIGITS   = 2;
   localparam int DEF_MODULUS  = 5;

   typedef logic [6:0] seg_t;

   // Active-high segments, bit 0 = a .. bit 6 = g, hex glyphs 0-F.
   localparam seg_t SEG_RESET = 7'b0111111;
   localparam seg_t SEG_GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   // Next value of one digit: load (clamped) wins, otherwise a wrapping step or hold.
   function automatic int next_digit(input int cur, input logic step, input logic up,
                                     input logic load, input int value, input int modulus);
      if (load) begin
         return (value >= modulus) ? modulus - 1 : value;
      end
      if (!step) begin
         return cur;
      end
      if (up) begin
         return (cur == modulus - 1) ? 0 : cur + 1;
      end
      return (cur == 0) ? modulus - 1 : cur - 1;
   endfunction

endpackage

// File: rtl/cascade_digit.sv
// One modulo-MODULUS digit with wrap-around up/down step and clamped synchronous load.
// Latency: one clock from step/load to digit.
// Backpressure: none; terminal flags tell the next stage when this digit is about to wrap.
module cascade_digit
   import cascade_counter_pkg::*;
#(
   parameter int MODULUS = DEF_MODULUS,
   parameter int DW      = (MODULUS <= 2) ? 1 : $clog2(MODULUS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          step,
   input  logic          up,
   input  logic          load,
   input  logic [DW-1:0] value,
   output logic [DW-1:0] digit,
   output logic          terminal
);

   logic [DW-1:0] digit_q;
   logic [DW-1:0] digit_d;

   // Next digit value from load/step/hold.
   always_comb begin
      digit_d = DW'(next_digit(32'(digit_q), step, up, load, 32'(value), MODULUS));
   end

   // Digit register with synchronous reset to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         digit_q <= '0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit    = digit_q;
   // Terminal depends on the live direction so the chain is correct on the step cycle.
   assign terminal = up ? (digit_q == DW'(MODULUS - 1)) : (digit_q == '0);

endmodule

// File: rtl/cascade_counter.sv
// Prescaled up/down counter built from DIGITS cascaded modulo-MODULUS digits, with load and carry.
// Latency: one clock from tick/load event to count, tick and carry; seg (CASCADE_COUNTER_SEG7_EN) tracks count.
// Backpressure: none; en freezes prescaler and digits, load and rst override counting.
module cascade_counter
   import cascade_counter_pkg::*;
#(
   parameter int PRESCALE = DEF_PRESCALE,
   parameter int DIGITS   = DEF_DIGITS,
   parameter int MODULUS  = DEF_MODULUS
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          up,
   input  logic                          load,
   input  logic [DIGITS*((MODULUS <= 2) ? 1 : $clog2(MODULUS))-1:0] load_val,
   output logic [DIGITS*((MODULUS <= 2) ? 1 : $clog2(MODULUS))-1:0] count,
   output logic                          tick,
   output logic                          carry
`ifdef CASCADE_COUNTER_SEG7_EN
   ,
   output logic [6:0]                    seg
`endif
);

   localparam int DW = (MODULUS <= 2) ? 1 : $clog2(MODULUS);
   localparam int PW = (PRESCALE <= 2) ? 1 : $clog2(PRESCALE);

   logic [PW-1:0]     presc_q;
   logic [PW-1:0]     presc_d;
   logic              tick_q;
   logic              tick_d;
   logic              carry_q;
   logic              carry_d;
   logic              tick_evt;
   logic [DIGITS-1:0] step_v;
   logic [DIGITS-1:0] term_v;

   // A tick happens at the end of a prescale period; load suppresses it.
   assign tick_evt = en && !load && (presc_q == PW'(PRESCALE - 1));

   // Prescaler next state: load clears, en advances with wrap, otherwise hold.
   always_comb begin
      presc_d = presc_q;
      if (load) begin
         presc_d = '0;
      end else if (en) begin
         presc_d = (presc_q == PW'(PRESCALE - 1)) ? '0 : presc_q + 1'b1;
      end
   end

   // Ripple the step enable up the chain: a digit steps only when every lower digit is terminal.
   always_comb begin
      step_v    = '0;
      step_v[0] = tick_evt;
      for (int i = 1; i < DIGITS; i++) begin
         step_v[i] = step_v[i-1] & term_v[i-1];
      end
      tick_d  = tick_evt;
      carry_d = tick_evt & (&term_v);
   end

   // Prescaler and pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= '0;
         tick_q  <= 1'b0;
         carry_q <= 1'b0;
      end else begin
         presc_q <= presc_d;
         tick_q  <= tick_d;
         carry_q <= carry_d;
      end
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      cascade_digit #(
         .MODULUS (MODULUS),
         .DW      (DW)
      ) u_digit (
         .clk      (clk),
         .rst      (rst),
         .step     (step_v[g]),
         .up       (up),
         .load     (load),
         .value    (load_val[g*DW +: DW]),
         .digit    (count[g*DW +: DW]),
         .terminal (term_v[g])
      );
   end

   assign tick  = tick_q;
   assign carry = carry_q;

`ifdef CASCADE_COUNTER_SEG7_EN
   seg_t seg_q;
   seg_t seg_d;

   // Decode the next value of digit 0 so seg lands in the same cycle as count.
   always_comb begin
      seg_d = SEG_GLYPH[4'(next_digit(32'(count[DW-1:0]), step_v[0], up, load,
                                      32'(load_val[DW-1:0]), MODULUS) & 32'hF)];
   end

   // Segment register, reset shows glyph 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_q <= SEG_RESET;
      end else begin
         seg_q <= seg_d;
      end
   end

   assign seg = seg_q;
`endif

endmodule

// File: tb/tb_cascade_counter.sv
// Scoreboard bench for cascade_counter with PRESCALE=4, DIGITS=2, MODULUS=5.
// Latency: expected outputs are pushed when inputs are driven and popped one clock later.
// Backpressure: n/a; seg checks are compiled in when CASCADE_COUNTER_SEG7_EN is defined.
module tb_cascade_counter;

   localparam int PRESCALE = 4;
   localparam int DIGITS   = 2;
   localparam int MODULUS  = 5;
   localparam int DW       = 3;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 en = 1'b0;
   logic                 up = 1'b1;
   logic                 load = 1'b0;
   logic [DIGITS*DW-1:0] load_val = '0;
   logic [DIGITS*DW-1:0] count;
   logic                 tick;
   logic                 carry;
`ifdef CASCADE_COUNTER_SEG7_EN
   logic [6:0]           seg;
`endif

   cascade_counter #(
      .PRESCALE (PRESCALE),
      .DIGITS   (DIGITS),
      .MODULUS  (MODULUS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .tick     (tick),
      .carry    (carry)
`ifdef CASCADE_COUNTER_SEG7_EN
      ,
      .seg      (seg)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: whole count as one integer 0..24, prescaler as an integer.
   int m_val   = 0;
   int m_presc = 0;
   logic [7:0] sb[$];   // {count[5:0], tick, carry}
   int checks = 0;
   int passes = 0;

   task automatic apply(input logic r, input logic e, input logic u, input logic l,
                        input logic [5:0] lv);
      logic t, c;
      int d0, d1;
      t = 1'b0;
      c = 1'b0;
      rst = r; en = e; up = u; load = l; load_val = lv;
      if (r) begin
         m_val = 0; m_presc = 0;
      end else if (l) begin
         d0 = int'(lv[2:0]); d1 = int'(lv[5:3]);
         if (d0 > 4) d0 = 4;
         if (d1 > 4) d1 = 4;
         m_val = d1 * 5 + d0; m_presc = 0;
      end else if (e) begin
         if (m_presc == PRESCALE - 1) begin
            m_presc = 0;
            t = 1'b1;
            if (u) begin
               c = (m_val == 24);
               m_val = (m_val + 1) % 25;
            end else begin
               c = (m_val == 0);
               m_val = (m_val + 24) % 25;
            end
         end else begin
            m_presc++;
         end
      end
      sb.push_back({3'(m_val / 5), 3'(m_val % 5), t, c});
   endtask

   task automatic test_reset();
      logic [7:0] exp;
      for (int i = 0; i < 2; i++) begin
         apply(1'b1, 1'b1, 1'b1, 1'b1, 6'o33);
         @(posedge clk); #1;
         exp = sb.pop_front();
         checks++;
         if ({count, tick, carry} !== exp)
            $display("FAIL reset: count=%h tick=%b carry=%b want %h", count, tick, carry, exp);
         else passes++;
      end
      checks++;
      if ({count, tick, carry} !== 8'h00)
         $display("FAIL reset_zero: got %h want 00", {count, tick, carry});
      else passes++;
`ifdef CASCADE_COUNTER_SEG7_EN
      checks++;
      if (seg !== 7'b0111111) $display("FAIL reset_seg: got %b want 0111111", seg);
      else passes++;
`endif
   endtask

   task automatic test_count_up();
      logic [7:0] exp;
      for (int i = 0; i < 100; i++) begin
         apply(1'b0, 1'b1, 1'b1, 1'b0, 6'o00);
         @(posedge clk); #1;
         exp = sb.pop_front();
         checks++;
         if ({count, tick, carry} !== exp)
            $display("FAIL count_up[%0d]: got %h want %h", i, {count, tick, carry}, exp);
         else passes++;
         if (i == 95) begin
            checks++;
            if ({count, tick, carry} !== {6'o44, 2'b10})
               $display("FAIL up_24_ticks: got %h want %h", {count, tick, carry}, {6'o44, 2'b10});
            else passes++;
         end
      end
      checks++;
      if ({count, tick, carry} !== {6'o00, 2'b11})
         $display("FAIL up_wrap_carry: got %h want %h", {count, tick, carry}, {6'o00, 2'b11});
      else passes++;
   endtask

   task automatic test_count_down();
      logic [7:0] exp;
      apply(1'b1, 1'b0, 1'b0, 1'b0, 6'o00);
      @(posedge clk); #1;
      void'(sb.pop_front());
      for (int i = 0; i < 4; i++) begin
         apply(1'b0, 1'b1, 1'b0, 1'b0, 6'o00);
         @(posedge clk); #1;
         exp = sb.pop_front();
         checks++;
         if ({count, tick, carry} !== exp)
            $display("FAIL count_down[%0d]: got %h want %h", i, {count, tick, carry}, exp);
         else passes++;
      end
      checks++;
      if ({count, tick, carry} !== {6'o44, 2'b11})
         $display("FAIL down_first_tick: got %h want %h", {count, tick, carry}, {6'o44, 2'b11});
      else passes++;
   endtask

   task automatic test_load();
      logic [7:0] exp;
      apply(1'b1, 1'b0, 1'b1, 1'b0, 6'o00);
      @(posedge clk); #1;
      void'(sb.pop_front());
      for (int i = 0; i < 7; i++) begin
         if (i == 2) apply(1'b0, 1'b1, 1'b1, 1'b1, 6'o23);
         else        apply(1'b0, 1'b1, 1'b1, 1'b0, 6'o00);
         @(posedge clk); #1;
         exp = sb.pop_front();
         checks++;
         if ({count, tick, carry} !== exp)
            $display("FAIL load[%0d]: got %h want %h", i, {count, tick, carry}, exp);
         else passes++;
         if (i == 2) begin
            checks++;
            if ({count, tick, carry} !== {6'o23, 2'b00})
               $display("FAIL load_value: got %h want %h", {count, tick, carry}, {6'o23, 2'b00});
            else passes++;
         end
      end
      checks++;
      if ({count, tick, carry} !== {6'o24, 2'b10})
         $display("FAIL load_next_tick: got %h want %h", {count, tick, carry}, {6'o24, 2'b10});
      else passes++;
   endtask

   task automatic test_en_hold();
      logic [7:0] exp;
      apply(1'b1, 1'b0, 1'b1, 1'b0, 6'o00);
      @(posedge clk); #1;
      void'(sb.pop_front());
      for (int i = 0; i < 14; i++) begin
         apply(1'b0, (i < 2 || i >= 12), 1'b1, 1'b0, 6'o00);
         @(posedge clk); #1;
         exp = sb.pop_front();
         checks++;
         if ({count, tick, carry} !== exp)
            $display("FAIL en_hold[%0d]: got %h want %h", i, {count, tick, carry}, exp);
         else passes++;
      end
      checks++;
      if ({count, tick, carry} !== {6'o01, 2'b10})
         $display("FAIL en_resume: got %h want %h", {count, tick, carry}, {6'o01, 2'b10});
      else passes++;
   endtask

   task automatic test_clamp();
      logic [7:0] exp;
      apply(1'b0, 1'b1, 1'b0, 1'b1, 6'o77);
      @(posedge clk); #1;
      exp = sb.pop_front();
      checks++;
      if ({count, tick, carry} !== exp || count !== 6'o44)
         $display("FAIL clamp: got %h want %h", {count, tick, carry}, exp);
      else passes++;
      apply(1'b0, 1'b0, 1'b1, 1'b1, 6'o03);
      @(posedge clk); #1;
      exp = sb.pop_front();
      checks++;
      if ({count, tick, carry} !== exp)
         $display("FAIL load_03: got %h want %h", {count, tick, carry}, exp);
      else passes++;
`ifdef CASCADE_COUNTER_SEG7_EN
      checks++;
      if (seg !== 7'b1001111) $display("FAIL seg_3: got %b want 1001111", seg);
      else passes++;
`endif
   endtask

   task automatic test_rst_priority();
      logic [7:0] exp;
      apply(1'b0, 1'b1, 1'b1, 1'b1, 6'o34);
      @(posedge clk); #1;
      void'(sb.pop_front());
      apply(1'b0, 1'b1, 1'b1, 1'b0, 6'o00);
      @(posedge clk); #1;
      void'(sb.pop_front());
      apply(1'b1, 1'b1, 1'b1, 1'b1, 6'o22);
      @(posedge clk); #1;
      exp = sb.pop_front();
      checks++;
      if ({count, tick, carry} !== exp || count !== 6'o00)
         $display("FAIL rst_priority: got %h want %h", {count, tick, carry}, exp);
      else passes++;
   endtask

   task automatic test_random();
      logic [7:0] exp;
      logic [5:0] lv;
      for (int i = 0; i < 400; i++) begin
         lv = 6'($urandom_range(0, 63));
         apply(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0), lv);
         @(posedge clk); #1;
         exp = sb.pop_front();
         checks++;
         if ({count, tick, carry} !== exp)
            $display("FAIL random[%0d]: got %h want %h", i, {count, tick, carry}, exp);
         else passes++;
      end
   endtask

   initial begin
      @(posedge clk); #1;
      test_reset();
      test_count_up();
      test_count_down();
      test_load();
      test_en_hold();
      test_clamp();
      test_rst_priority();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
